// File: rtl/bin_to_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM state encoding, the digit-adjust constants and the helper
// that sizes the BCD field for a given binary width.
package bin_to_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // Smallest digit count n with 10^n > 2^width-1.
    function automatic int bcd_digits_for(input int width);
        longint unsigned max_val;
        longint unsigned pow10;
        int              n;
        max_val = (64'd1 << width) - 64'd1;
        pow10   = 64'd1;
        n       = 0;
        while (pow10 <= max_val) begin
            pow10 = pow10 * 64'd10;
            n     = n + 1;
        end
        if (n == 0) n = 1;
        return n;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle between the counter domain, the converter and the
// display stage. The converter takes the slave view; the producer/consumer
// side takes the master view.
interface bin_to_bcd_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic [WIDTH-1:0]    bin_in;
    logic                in_valid;
    logic                in_ready;
    logic [4*DIGITS-1:0] bcd_out;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output bin_in, in_valid, out_ready,
        input  in_ready, bcd_out, out_valid
    );

    modport slave (
        input  bin_in, in_valid, out_ready,
        output in_ready, bcd_out, out_valid
    );
endinterface

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next digit.
module bcd_digit_adj
    import bin_to_bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);
    assign o_digit = (i_digit >= BCD_ADJ_THRESH) ? (i_digit + BCD_ADJ_ADD) : i_digit;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-packed-BCD converter, one shift per clock.
// State table:
//   IDLE  | in_ready high, waiting for a sample
//   SHIFT | adjust-then-shift, one binary bit per edge
//   DONE  | result held on bcd_out until the consumer takes it
// Optional macro BIN_TO_BCD_CHANGE_DETECT_EN: drop a sample equal to the last
// accepted one, so a saturated upstream counter does not retrigger the engine.
module bin_to_bcd_seq
    import bin_to_bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clck,
    input  logic                  rst,
    bin_to_bcd_seq_if.slave       bus
);
    localparam int SR_W  = 4*DIGITS + WIDTH;
    localparam int BCD_W = 4*DIGITS;
    localparam int CNT_W = $clog2(WIDTH+1);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_SHIFT = SHIFT;
    localparam logic [1:0] S_DONE  = DONE;

    if (DIGITS < bcd_digits_for(WIDTH)) begin : g_bad_digits
        $error("bin_to_bcd_seq: DIGITS too small to hold 2^WIDTH-1");
    end

    logic [1:0]       r_state;
    logic [SR_W-1:0]  r_sr;
    logic [CNT_W-1:0] r_cnt;
    logic [BCD_W-1:0] r_bcd;

    logic [SR_W-1:0]  w_adj;
    logic [SR_W-1:0]  w_shift;
    logic             w_last;
    logic             w_start;

    // All digits are corrected in parallel before the shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_sr[WIDTH + 4*g +: 4]),
            .o_digit (w_adj[WIDTH + 4*g +: 4])
        );
    end

    assign w_adj[WIDTH-1:0] = r_sr[WIDTH-1:0];
    assign w_shift          = {w_adj[SR_W-2:0], 1'b0};
    assign w_last           = (r_cnt == CNT_W'(WIDTH-1));

`ifdef BIN_TO_BCD_CHANGE_DETECT_EN
    logic [WIDTH-1:0] r_last;
    logic             r_last_vld;
    logic             w_dup;

    assign w_dup   = r_last_vld && (bus.bin_in == r_last);
    assign w_start = bus.in_valid && !w_dup;

    // Remember the last value that actually started a conversion.
    always_ff @(posedge clck or posedge rst) begin
        if (rst) begin
            r_last     <= '0;
            r_last_vld <= 1'b0;
        end else if (r_state == S_IDLE && w_start) begin
            r_last     <= bus.bin_in;
            r_last_vld <= 1'b1;
        end
    end
`else
    assign w_start = bus.in_valid;
`endif

    // Control FSM and shift engine; reset aborts any conversion in flight.
    always_ff @(posedge clck or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_sr    <= {{BCD_W{1'b0}}, bus.bin_in};
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_sr  <= w_shift;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_bcd   <= w_shift[SR_W-1 -: BCD_W];
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.bcd_out   = r_bcd;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: directed sequences plus a scoreboard that queues
// the expected BCD on every accepted input and compares on every output
// handshake. Build with BIN_TO_BCD_CHANGE_DETECT_EN to cover the drop path.
module tb_bin_to_bcd_seq;
    logic clck;
    logic rst;

    bin_to_bcd_seq_if #(.WIDTH(8), .DIGITS(3)) bus ();

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clck (clck),
        .rst  (rst),
        .bus  (bus)
    );

    int          n_vec  = 0;
    int          n_miss = 0;
    int          n_out  = 0;
    logic [11:0] last_out = '0;
    logic [11:0] exp_q[$];
`ifdef BIN_TO_BCD_CHANGE_DETECT_EN
    logic [7:0]  m_last = '0;
    logic        m_last_vld = 1'b0;
`endif

    initial clck = 1'b0;
    always #5 clck = ~clck;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input logic [7:0] v);
        int          x;
        logic [11:0] r;
        x        = int'(v);
        r[3:0]   = 4'(x % 10);
        r[7:4]   = 4'((x / 10) % 10);
        r[11:8]  = 4'(x / 100);
        return r;
    endfunction

    // Scoreboard: push on input handshake, pop and compare on output handshake.
    always @(negedge clck) begin
        if (rst) begin
            exp_q.delete();
`ifdef BIN_TO_BCD_CHANGE_DETECT_EN
            m_last_vld = 1'b0;
`endif
        end else begin
            if (bus.in_valid && bus.in_ready) begin
`ifdef BIN_TO_BCD_CHANGE_DETECT_EN
                if (!(m_last_vld && bus.bin_in == m_last)) begin
                    exp_q.push_back(to_bcd(bus.bin_in));
                    m_last     = bus.bin_in;
                    m_last_vld = 1'b1;
                end
`else
                exp_q.push_back(to_bcd(bus.bin_in));
`endif
            end
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                last_out = bus.bcd_out;
                if (exp_q.size() == 0) check("spurious_out", exp_q.size(), 1);
                else check("bcd_out", bus.bcd_out, exp_q.pop_front());
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clck); #1;
            n++;
        end
        if (!bus.in_ready) check("idle_timeout", bus.in_ready, 1);
    endtask

    task automatic send(input logic [7:0] v);
        wait_idle();
        bus.bin_in   = v;
        bus.in_valid = 1'b1;
        @(posedge clck); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clck);
        @(posedge clck); #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          cyc;
        int          bad;
        int          n0;
        logic [7:0]  cnt;
        logic [7:0]  sweep [5];
        sweep = '{8'd5, 8'd0, 8'd255, 8'd99, 8'd100};

        rst           = 1'b1;
        bus.bin_in    = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_bcd_out", bus.bcd_out, 0);
        @(posedge clck); #1;
        rst = 1'b0;

        // Single conversion and latency from acceptance.
        send(8'd64);
        check("busy_after_accept", bus.in_ready, 0);
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(posedge clck); #1;
            cyc++;
        end
        check("latency", cyc, 8);
        check("bcd_64", bus.bcd_out, 12'h064);
        wait_idle();

        // Back-to-back with in_valid held high.
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.bin_in = sweep[i];
            wait_idle();
            @(posedge clck); #1;
            if (i == 4) bus.in_valid = 1'b0;
            cyc = 0;
            while (!bus.in_ready && cyc < 30) begin
                @(posedge clck); #1;
                cyc++;
            end
            check("sweep_busy_cycles", cyc, 9);
        end
        check("sweep_drained", exp_q.size(), 0);

        // Backpressure holds the result.
        bus.out_ready = 1'b0;
        send(8'd123);
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(posedge clck); #1;
            cyc++;
        end
        bad = 0;
        repeat (20) begin
            @(posedge clck); #1;
            if (!(bus.out_valid && bus.bcd_out == 12'h123 && !bus.in_ready)) bad++;
        end
        check("bp_hold", bad, 0);
        check("bp_bcd", bus.bcd_out, 12'h123);
        bus.out_ready = 1'b1;
        @(posedge clck); #1;
        check("bp_release_valid", bus.out_valid, 0);
        check("bp_release_ready", bus.in_ready, 1);
        check("bp_release_hold", bus.bcd_out, 12'h123);

        // Reset in the middle of a conversion.
        send(8'd200);
        repeat (3) @(posedge clck);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_bcd_out", bus.bcd_out, 0);
        @(negedge clck);
        @(posedge clck); #1;
        rst = 1'b0;
        n0 = n_out;
        send(8'd7);
        wait_idle();
        check("post_rst_count", n_out - n0, 1);
        check("post_rst_bcd", last_out, 12'h007);

        // Upstream saturating counter 5..64.
        cnt = 8'd5;
        bus.in_valid = 1'b1;
        repeat (200) begin
            bus.bin_in = cnt;
            @(posedge clck); #1;
            if (cnt < 8'd64) cnt = cnt + 8'd1;
        end
        bus.in_valid = 1'b0;
        wait_idle();
        check("cnt_drained", exp_q.size(), 0);
        check("cnt_final", last_out, 12'h064);

        // Repeated identical samples.
        do_reset();
        n0 = n_out;
        send(8'd64);
        wait_idle();
        send(8'd64);
`ifdef BIN_TO_BCD_CHANGE_DETECT_EN
        check("dup_stays_idle", bus.in_ready, 1);
`else
        check("dup_converts", bus.in_ready, 0);
`endif
        wait_idle();
        send(8'd64);
        wait_idle();
`ifdef BIN_TO_BCD_CHANGE_DETECT_EN
        check("dup_pulses", n_out - n0, 1);
`else
        check("dup_pulses", n_out - n0, 3);
`endif
        send(8'd63);
        wait_idle();
        check("new_val_bcd", last_out, 12'h063);
        do_reset();
        n0 = n_out;
        send(8'd64);
        wait_idle();
        check("after_rst_pulses", n_out - n0, 1);
        check("after_rst_bcd", last_out, 12'h064);
        check("final_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Downstream consumer of the 8-bit free-running/saturating counter value (count, 0..255).
- Converts each accepted binary sample to packed BCD with a sequential shift-add-3 (double-dabble) engine, one bit per clock.
- Result feeds the display/decoder stage.
- Valid/ready handshake on both sides, so the counter domain never stalls on conversion.

Parameters:
- WIDTH, 8, binary input width.
- DIGITS, 3, BCD output digits; must satisfy 10^DIGITS > 2^WIDTH-1. Elaboration error otherwise.

Ports:
- clck  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- bin_in  input  WIDTH  binary value to convert (counter output).
- in_valid  input  1  bin_in is valid.
- in_ready  output  1  block can accept a sample (high only in IDLE).
- bcd_out  output  4*DIGITS  packed BCD result, digit 0 in [3:0].
- out_valid  output  1  bcd_out holds a completed conversion.
- out_ready  input  1  downstream accepts bcd_out.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, in_ready=1, out_valid=0, bcd_out=0.
  - Internal shift register and bit counter are cleared.
  - Reset mid-conversion aborts the conversion with no partial output.
- Internal storage:
  - Shift register of 4*DIGITS+WIDTH bits: BCD field on top, binary field below.
  - Bit counter of clog2(WIDTH+1) bits.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, bin_in is loaded into the binary field, the BCD field is zeroed, the bit counter is set to 0, and the FSM goes to SHIFT.
  - With in_valid=0, stay in IDLE.
- SHIFT:
  - in_ready=0.
  - Each edge, every BCD digit >= 5 gets +3 (combinational, all digits in parallel), then the whole register shifts left by 1 and the bit counter increments.
  - When the counter reaches WIDTH-1 on an edge, that is the last shift: go to DONE and register the BCD field into bcd_out.
- DONE:
  - out_valid=1; bcd_out is stable while out_valid=1 and out_ready=0 (backpressure).
  - On an edge with out_ready=1: out_valid goes to 0 and the FSM goes to IDLE; bcd_out holds its last value.
  - in_ready stays 0 in DONE; no overlap of input acceptance with pending output.
- Latency:
  - Acceptance edge E0; shifts on edges E1..E_WIDTH.
  - out_valid is high after edge E_WIDTH (8 cycles for the default).
  - Minimum initiation interval is WIDTH+2 cycles with out_ready tied high.
- Arithmetic:
  - The digit adjust is 4-bit unsigned; no digit ever exceeds 9 after the final shift for legal parameters.
  - The binary field shifts in zeros.
- Boundary cases:
  - bin_in=0 -> 0x000.
  - bin_in=2^WIDTH-1 -> 0x255.
  - in_valid held high continuously: exactly one sample is accepted per IDLE visit.
  - out_valid/out_ready both high with in_valid high: return to IDLE first; the next sample is accepted one edge later.

Optional Feature:
- Macro: BIN_TO_BCD_CHANGE_DETECT_EN.
- Defined:
  - A last-accepted value register plus a last_vld flag (cleared by rst).
  - In IDLE, a handshake whose bin_in equals the stored value while last_vld=1 is consumed (in_ready=1) but dropped. The FSM stays in IDLE and no out_valid is produced.
  - Otherwise the value is stored, last_vld is set, and the conversion starts.
  - This suppresses redundant conversions while the upstream counter sits saturated at its terminal value.
- Undefined: every handshake starts a conversion; the register and flag are not synthesised.

Decomposition:
- Package bin_to_bcd_pkg:
  - State enum typedef (IDLE, SHIFT, DONE).
  - Constants: BCD_ADJ_THRESH=5, BCD_ADJ_ADD=3.
  - Function computing required DIGITS from WIDTH, used for the elaboration check.
- Sub-module bcd_digit_adj: combinational 4-bit in, 4-bit out (adds 3 when >= 5); instantiated DIGITS times via generate.

Test Plan:
- Reset, then bin_in=64 with in_valid pulse and out_ready=1 -> out_valid high 8 cycles after acceptance; bcd_out=0x064.
- Sweep: bin_in=5, 0, 255, 99, 100 back-to-back with in_valid held high -> bcd_out 0x005, 0x000, 0x255, 0x099, 0x100 in order; in_ready low during SHIFT/DONE.
- Backpressure: bin_in=123, out_ready=0 for 20 cycles -> out_valid and bcd_out=0x123 held stable with in_ready=0; then out_ready=1 for one edge -> out_valid=0 and in_ready=1 next cycle.
- Reset mid-op: assert rst 3 cycles after accepting 200 -> out_valid=0, in_ready=1 immediately (async); no stale output; next sample 7 -> 0x007.
- Upstream integration: drive from the 8-bit counter starting at 5 and saturating at 64 -> every emitted result matches BCD of the accepted count; the final result is 0x064.
- With BIN_TO_BCD_CHANGE_DETECT_EN: present 64 three times -> exactly one out_valid pulse. Then present 63 -> a second pulse with 0x063. After rst, present 64 -> it is converted again.
